dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed-latency request/response handshake.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned/out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        resp_err,
`endif
  output logic [31:0] resp_rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_we;
  logic              addr_bad;

  logic [31:0] mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_bad = (addr[1:0] != 2'b00) || ((addr >> (IdxW + 2)) != 32'd0);
  assign resp_err = rerr_q;
`else
  // Byte offset and wrapped upper bits are intentionally discarded.
  logic unused_addr;
  assign unused_addr = ^{addr[31:IdxW+2], addr[1:0]};
  assign addr_bad    = 1'b0;
`endif

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    store_d = store_q;
    load_d  = load_q;
    err_d   = err_q;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          idx_d   = addr[IdxW+1:2];
          wdata_d = wdata;
          store_d = mem_write;
          load_d  = mem_read & ~mem_write;
          err_d   = addr_bad;
          cnt_d   = CntInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          mem_we  = store_q & ~err_q;
          rdata_d = (load_q && !err_q) ? mem[idx_q] : 32'd0;
          rerr_d  = err_q;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      load_q  <= load_d;
      err_q   <= err_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is deliberately outside the reset domain; reset only blocks the write via state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

endmodule
